// File: rtl/text_line_parser.sv
// Parses ASCII lines of the form [RL]<digits>\n into {dir, value[30:0]} packets.
// Optional malformed-line counter built only when TEXT_LINE_PARSER_ERRCNT_EN is defined.
module text_line_parser (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_byteValid,
  input  logic [7:0]  i_byte,
  input  logic        i_last,
  output logic        o_dataValid,
  output logic [31:0] o_packet,
  output logic [15:0] o_errCount,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, DIR, DIGITS, SKIP} state_t;

  typedef struct packed {
    state_t      state;
    logic [30:0] acc;
    logic        load_dir;
    logic        emit;
    logic        err;
  } step_t;

  localparam logic [7:0]  CH_LF   = 8'h0A;
  localparam logic [7:0]  CH_CR   = 8'h0D;
  localparam logic [7:0]  CH_R    = 8'h52;
  localparam logic [7:0]  CH_L    = 8'h4C;
  localparam logic [30:0] ACC_MAX = 31'h7FFF_FFFF;

  state_t      state_reg;
  logic [30:0] acc_reg;
  logic        dir_reg;

  step_t       s1_step;
  step_t       s2_step;
  step_t       fin_step;
  logic        dir_next;
  logic        emit_any;

  // One byte of the line grammar applied to a given state/accumulator.
  function automatic step_t parse_step(input state_t st, input logic [30:0] acc,
                                       input logic [7:0] b);
    step_t       r;
    logic        is_digit;
    logic [34:0] prod;
    r.state    = st;
    r.acc      = acc;
    r.load_dir = 1'b0;
    r.emit     = 1'b0;
    r.err      = 1'b0;
    is_digit   = (b >= 8'h30) && (b <= 8'h39);
    prod       = ({4'd0, acc} * 35'd10) + {31'd0, b[3:0]};
    case (st)
      IDLE: begin
        if (b == CH_R || b == CH_L) begin
          r.state    = DIR;
          r.acc      = '0;
          r.load_dir = 1'b1;
        end else if (b != CH_LF && b != CH_CR) begin
          r.state = SKIP;
          r.err   = 1'b1;
        end
      end
      DIR: begin
        if (is_digit) begin
          r.state = DIGITS;
          r.acc   = {27'd0, b[3:0]};
        end else if (b == CH_LF) begin
          r.state = IDLE;
          r.err   = 1'b1;
        end else begin
          r.state = SKIP;
          r.err   = 1'b1;
        end
      end
      DIGITS: begin
        if (is_digit) begin
          r.acc = (prod > {4'd0, ACC_MAX}) ? ACC_MAX : prod[30:0];
        end else if (b == CH_LF) begin
          r.state = IDLE;
          r.emit  = 1'b1;
        end else if (b != CH_CR) begin
          r.state = SKIP;
          r.err   = 1'b1;
        end
      end
      default: begin
        if (b == CH_LF) r.state = IDLE;
      end
    endcase
    return r;
  endfunction

  // i_last is modelled as a second, implicit '\n' step in the same cycle.
  always_comb begin
    s1_step  = parse_step(state_reg, acc_reg, i_byte);
    s2_step  = parse_step(s1_step.state, s1_step.acc, CH_LF);
    fin_step = i_last ? s2_step : s1_step;
    dir_next = s1_step.load_dir ? (i_byte == CH_R) : dir_reg;
    emit_any = s1_step.emit | (i_last & s2_step.emit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      dir_reg     <= 1'b0;
      o_dataValid <= 1'b0;
      o_packet    <= '0;
      o_busy      <= 1'b0;
    end else if (i_byteValid) begin
      state_reg   <= fin_step.state;
      acc_reg     <= fin_step.acc;
      dir_reg     <= dir_next;
      o_dataValid <= emit_any;
      o_busy      <= (fin_step.state != IDLE);
      if (emit_any) o_packet <= {dir_next, fin_step.acc};
    end else begin
      o_dataValid <= 1'b0;
    end
  end

`ifdef TEXT_LINE_PARSER_ERRCNT_EN
  logic [15:0] err_count_reg;
  logic        err_any;

  // At most one error event can occur per line, so each event is one line.
  assign err_any = s1_step.err | (i_last & s2_step.err);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count_reg <= '0;
    end else if (i_byteValid && err_any && err_count_reg != 16'hFFFF) begin
      err_count_reg <= err_count_reg + 16'd1;
    end
  end

  assign o_errCount = err_count_reg;
`else
  assign o_errCount = '0;
`endif

endmodule

// File: tb/tb_text_line_parser.sv
// Scoreboard bench for text_line_parser: expected packets queued at stimulus time,
// a forked monitor pops and compares on every o_dataValid strobe.
module tb_text_line_parser;

  logic        clk;
  logic        rst;
  logic        i_byteValid;
  logic [7:0]  i_byte;
  logic        i_last;
  logic        o_dataValid;
  logic [31:0] o_packet;
  logic [15:0] o_errCount;
  logic        o_busy;

  int          checks;
  int          failures;
  logic [31:0] exp_q[$];
  logic [15:0] exp_err;

  text_line_parser dut (
    .clk         (clk),
    .rst         (rst),
    .i_byteValid (i_byteValid),
    .i_byte      (i_byte),
    .i_last      (i_last),
    .o_dataValid (o_dataValid),
    .o_packet    (o_packet),
    .o_errCount  (o_errCount),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end else begin
      $display("ok   %s value=%h", name, got);
    end
  endtask

  // Runs forever on the falling edge, half a cycle after outputs update.
  task automatic monitor_loop();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst && o_dataValid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_packet got=%h expected=none", o_packet);
        end else begin
          e = exp_q.pop_front();
          if (o_packet !== e) begin
            failures++;
            $display("FAIL packet got=%h expected=%h", o_packet, e);
          end else begin
            $display("ok   packet value=%h", o_packet);
          end
        end
      end
    end
  endtask

  // Called at a falling edge; byte is taken on the next rising edge, returns at the following falling edge.
  task automatic send(input logic [7:0] b, input logic last);
    i_byteValid = 1'b1;
    i_byte      = b;
    i_last      = last;
    @(negedge clk);
    i_byteValid = 1'b0;
    i_last      = 1'b0;
  endtask

  task automatic idle(input int n);
    i_byteValid = 1'b0;
    i_last      = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_str(input string s, input bit last_on_end, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], last_on_end && (i == s.len() - 1));
      if (gap > 0) idle(gap);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    i_byteValid = 1'b0;
    i_byte      = 8'h00;
    i_last      = 1'b0;
`ifdef TEXT_LINE_PARSER_ERRCNT_EN
    exp_err = 16'd2;
`else
    exp_err = 16'd0;
`endif

    repeat (3) @(negedge clk);
    chk("reset_dataValid", {31'd0, o_dataValid}, 32'd0);
    chk("reset_packet", o_packet, 32'd0);
    chk("reset_errCount", {16'd0, o_errCount}, 32'd0);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b1;
    fork
      monitor_loop();
    join_none
    idle(1);

    // Strobe lands exactly one cycle after '\n' is accepted, and lasts one cycle.
    exp_q.push_back(32'h0000_0044);
    send_str("L68", 1'b0, 0);
    send(8'h0A, 1'b0);
    chk("l68_strobe_on", {31'd0, o_dataValid}, 32'd1);
    idle(1);
    chk("l68_strobe_off", {31'd0, o_dataValid}, 32'd0);
    chk("l68_busy_after", {31'd0, o_busy}, 32'd0);

    exp_q.push_back(32'h8000_0030);
    exp_q.push_back(32'h0000_0005);
    send_str("R4", 1'b0, 2);
    chk("gap_busy_held", {31'd0, o_busy}, 32'd1);
    send_str("8\r\n", 1'b0, 2);
    chk("gap_packet_held", o_packet, 32'h8000_0030);
    send_str("L5\n", 1'b0, 2);

    exp_q.push_back(32'hFFFF_FFFF);
    send_str("R2147483648\n", 1'b0, 0);
    exp_q.push_back(32'h7FFF_FFFF);
    send_str("L99999999999\n", 1'b0, 0);
    idle(2);

    exp_q.push_back(32'h0000_0007);
    send_str("X12\nR\nL7\n", 1'b0, 0);
    idle(2);
    chk("errCount_two_bad_lines", {16'd0, o_errCount}, {16'd0, exp_err});

    exp_q.push_back(32'h0000_0063);
    send_str("L99", 1'b1, 0);
    idle(2);
    chk("last_busy_after", {31'd0, o_busy}, 32'd0);

    // Reset mid-line: partial line dropped, packet/counter cleared.
    send_str("R1", 1'b0, 0);
    chk("midline_busy", {31'd0, o_busy}, 32'd1);
    rst = 1'b0;
    idle(2);
    chk("midreset_packet", o_packet, 32'd0);
    chk("midreset_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b1;
    idle(1);
    send_str("2\n", 1'b0, 0);
    idle(3);
`ifdef TEXT_LINE_PARSER_ERRCNT_EN
    exp_err = 16'd1;
`else
    exp_err = 16'd0;
`endif
    chk("errCount_after_reset", {16'd0, o_errCount}, {16'd0, exp_err});
    chk("no_pending_packets", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_line_parser.md
TEXT_LINE_PARSER -- requirements
Module: text_line_parser

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 Port: i_byteValid  input  1  i_byte is valid this cycle; one byte is consumed per cycle when high.
REQ-005 Port: i_byte  input  8  ASCII input character.
REQ-006 Port: i_last  input  1  qualified by i_byteValid; marks the final byte of the stream.
REQ-007 Port: o_dataValid  output  1  one-cycle strobe; o_packet is valid.
REQ-008 Port: o_packet  output  32  {dir, value[30:0]}; dir 1 = R, 0 = L; drives the processor's i_dataValid/i_packet directly.
REQ-009 Port: o_errCount  output  16  count of malformed lines.
REQ-010 Port: o_busy  output  1  high while a line is partially parsed (state is not IDLE).

Function
REQ-011 The FSM SHALL have four states: IDLE, DIR, DIGITS and SKIP; bytes are consumed only on a rising edge with i_byteValid=1.
REQ-012 In IDLE, 'R' (0x52) and 'L' (0x4C) SHALL latch dir, clear the accumulator and go to DIR.
- '\n' (0x0A) and '\r' (0x0D) are ignored.
- Any other byte is an error and goes to SKIP.
REQ-013 In DIR, a digit '0'-'9' SHALL load acc = digit and go to DIGITS.
- '\n' is an error and goes to IDLE.
- Any other byte is an error and goes to SKIP.
REQ-014 In DIGITS, a digit SHALL update acc = acc*10 + digit, computed at 35-bit width.
- If the result exceeds 0x7FFFFFFF, acc saturates to 0x7FFFFFFF and stays saturated for the rest of the line.
REQ-015 In DIGITS, '\r' SHALL be ignored.
- '\n' emits a packet and goes to IDLE.
- Any other byte is an error and goes to SKIP.
REQ-016 In SKIP, all bytes SHALL be discarded until '\n', which returns the FSM to IDLE.
REQ-017 An error SHALL increment o_errCount once per line, saturating at 0xFFFF.
REQ-018 Emit timing: if the terminator is accepted at edge N, o_dataValid SHALL be 1 for exactly the cycle between edges N and N+1, with o_packet = {dir, acc}.
REQ-019 o_packet SHALL hold its last emitted value while o_dataValid is 0.
REQ-020 i_last on an accepted byte SHALL behave as if a '\n' followed that byte in the same cycle.
- In DIGITS, a digit byte with i_last is accumulated first, then the packet is emitted.
- In DIR, i_last with a non-digit is an error.
- The FSM returns to IDLE in all cases.
REQ-021 Input gaps (i_byteValid=0) SHALL NOT change state, acc or any output except clearing o_dataValid.
REQ-022 Throughput SHALL be one byte per cycle with no back-pressure; the shortest line is 3 bytes, so strobes are never adjacent.

Reset
REQ-023 With rst=0, the block SHALL asynchronously force:
- state=IDLE, acc=0, dir=0
- o_dataValid=0, o_packet=0, o_errCount=0, o_busy=0
REQ-024 A reset asserted mid-line SHALL discard the partial line with no packet and no error count.
REQ-025 After rst deasserts, the first byte SHALL be accepted on the first rising edge with i_byteValid=1.

Configuration
REQ-026 Macro TEXT_LINE_PARSER_ERRCNT_EN, when defined, SHALL build the 16-bit saturating error counter as specified in REQ-017.
REQ-027 When TEXT_LINE_PARSER_ERRCNT_EN is undefined:
- o_errCount SHALL be tied to 0 and no counter register exists.
- Error handling and FSM behaviour are unchanged.

Verification
REQ-028 Stimulus "L68\n" -> exactly one o_dataValid pulse, one cycle after '\n' is accepted, with o_packet=0x00000044.
REQ-029 Stimulus "R48\r\n" followed by "L5\n" with 2-cycle gaps -> packets 0x80000030 then 0x00000005; the state during the gaps is held.
REQ-030 Stimulus "R2147483648\n" -> o_packet=0xFFFFFFFF (saturated value); "L99999999999\n" -> o_packet=0x7FFFFFFF.
REQ-031 Stimulus "X12\nR\nL7\n" -> o_errCount=2 (=0 without macro) and a single packet 0x00000007.
REQ-032 Stimulus "L99" with i_last on the final '9' -> packet 0x00000063; o_busy=0 afterwards.
REQ-033 Stimulus "R1", then rst=0 for 2 cycles, then "2\n" -> no packet; '2' is an error in IDLE, so o_errCount=1.
